ieeedrv_sd_arb: RTL and testbench

// - Upstream of the drive's SD block port: shares one MiSTer image-slot request channel between NCLI drive units.
// - Each drive unit presents sd_lba/sd_blk_cnt/sd_rd/sd_wr/sd_buff_din.
// - Block grants one client at a time round-robin and forwards its request to the host side.
// - Routes host sd_ack back to the granted client only.

---
 rtl/ieeedrv_pkg.sv | 20 ++
 rtl/ieeedrv_sd_arb.sv | 197 +++++++++++++++++++
 tb/tb_ieeedrv_sd_arb.sv | 357 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ieeedrv_pkg.sv
// ieeedrv_pkg
// Shared definitions for the IEEE drive SD-port blocks.
//   SD_LBA_W / SD_CNT_W / SD_DAT_W : widths of block address, block count and data byte
//   arb_state_e                    : states of the SD request arbiter
`timescale 1ns/1ps

package ieeedrv_pkg;

    localparam int SD_LBA_W = 32;
    localparam int SD_CNT_W = 6;
    localparam int SD_DAT_W = 8;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_REQ,
        ARB_XFER,
        ARB_GAP
    } arb_state_e;

endpackage

// File: rtl/ieeedrv_sd_arb.sv
// ieeedrv_sd_arb
// Shares one MiSTer image-slot SD request channel between NCLI drive units.
// One client is granted at a time, chosen round-robin. Its address, count and
// direction are latched and forwarded to the host. The host ack is routed back
// to that client only.
// Ports:
//   clk_sys, reset          : system clock, synchronous active-high reset
//   cl_lba_i / cl_blk_cnt_i : per-client block address / block count-1 (packed, client 0 in LSBs)
//   cl_rd_i / cl_wr_i       : per-client request levels, held until ack
//   cl_buff_din_i           : per-client write data (packed)
//   cl_ack_o                : per-client ack, at most one bit set
//   cl_err_o                : one-cycle pulse when a client's request timed out
//   sd_lba_o / sd_blk_cnt_o : latched request of the granted client
//   sd_rd_o / sd_wr_o       : host request strobes
//   sd_ack_i                : host ack
//   sd_buff_din_o           : write data of the granted client, 0 without a grant
//   busy_o                  : arbiter is not idle
`timescale 1ns/1ps

module ieeedrv_sd_arb
    import ieeedrv_pkg::*;
#(
    parameter int NCLI    = 2,
    parameter int TIMEOUT = 2**24 - 1
) (
    input  logic                     clk_sys,
    input  logic                     reset,
    input  logic [NCLI*SD_LBA_W-1:0] cl_lba_i,
    input  logic [NCLI*SD_CNT_W-1:0] cl_blk_cnt_i,
    input  logic [NCLI-1:0]          cl_rd_i,
    input  logic [NCLI-1:0]          cl_wr_i,
    output logic [NCLI-1:0]          cl_ack_o,
    input  logic [NCLI*SD_DAT_W-1:0] cl_buff_din_i,
    output logic [NCLI-1:0]          cl_err_o,
    output logic [SD_LBA_W-1:0]      sd_lba_o,
    output logic [SD_CNT_W-1:0]      sd_blk_cnt_o,
    output logic                     sd_rd_o,
    output logic                     sd_wr_o,
    input  logic                     sd_ack_i,
    output logic [SD_DAT_W-1:0]      sd_buff_din_o,
    output logic                     busy_o
);

    localparam int IW = (NCLI > 1) ? $clog2(NCLI) : 1;
    localparam int TW = $clog2(TIMEOUT + 1);

    arb_state_e          state_q,  state_d;
    logic [IW-1:0]       rr_q,     rr_d;
    logic [SD_LBA_W-1:0] lba_q,    lba_d;
    logic [SD_CNT_W-1:0] blkCnt_q, blkCnt_d;
    logic [TW-1:0]       timer_q,  timer_d;
    logic                sdRd_q,   sdRd_d;
    logic                sdWr_q,   sdWr_d;
    logic [NCLI-1:0]     clAck_q,  clAck_d;
    logic [NCLI-1:0]     clErr_q,  clErr_d;
    logic                ackPrev_q;

    logic [SD_LBA_W-1:0] lbaArr  [NCLI];
    logic [SD_CNT_W-1:0] cntArr  [NCLI];
    logic [SD_DAT_W-1:0] buffArr [NCLI];
    logic [IW:0]         pick;
    logic [IW-1:0]       winner;
    logic                ackRise;
    logic                ackFall;

    // Round-robin pick: scan last+1, last+2 ... wrapping, so the client served
    // last is looked at last. Scanning backwards lets the nearest hit win.
    // Returns {found, index}.
    function automatic logic [IW:0] pickNext(input logic [NCLI-1:0] req,
                                             input logic [IW-1:0]   last);
        logic [IW:0]   found;
        logic [IW-1:0] sel;
        int            idx;
        found = '0;
        for (int k = NCLI; k >= 1; k--) begin
            idx = (int'(last) + k) % NCLI;
            sel = IW'(idx);
            if (req[sel]) begin
                found = {1'b1, sel};
            end
        end
        return found;
    endfunction

    // Split the packed client buses into per-client views for indexing.
    always_comb begin
        for (int i = 0; i < NCLI; i++) begin
            lbaArr[i]  = cl_lba_i[i*SD_LBA_W +: SD_LBA_W];
            cntArr[i]  = cl_blk_cnt_i[i*SD_CNT_W +: SD_CNT_W];
            buffArr[i] = cl_buff_din_i[i*SD_DAT_W +: SD_DAT_W];
        end
    end

    // Next-state logic. rr_q doubles as the grant index while a request is
    // active, since the winner always becomes the new round-robin pointer.
    // Ack edges are taken against the previous-cycle ack so a level held over
    // from an earlier transfer cannot complete a new request.
    always_comb begin
        state_d  = state_q;
        rr_d     = rr_q;
        lba_d    = lba_q;
        blkCnt_d = blkCnt_q;
        timer_d  = timer_q;
        sdRd_d   = sdRd_q;
        sdWr_d   = sdWr_q;
        clAck_d  = '0;
        clErr_d  = '0;
        pick     = pickNext(cl_rd_i | cl_wr_i, rr_q);
        winner   = pick[IW-1:0];
        ackRise  = sd_ack_i & ~ackPrev_q;
        ackFall  = ~sd_ack_i & ackPrev_q;

        case (state_q)
            ARB_IDLE: begin
                sdRd_d = 1'b0;
                sdWr_d = 1'b0;
                // A stale host ack must clear before anything new is granted.
                if (!sd_ack_i && pick[IW]) begin
                    rr_d     = winner;
                    lba_d    = lbaArr[winner];
                    blkCnt_d = cntArr[winner];
                    sdRd_d   = cl_rd_i[winner];
                    sdWr_d   = ~cl_rd_i[winner];
                    timer_d  = '0;
                    state_d  = ARB_REQ;
                end
            end
            ARB_REQ: begin
                if (ackRise) begin
                    sdRd_d       = 1'b0;
                    sdWr_d       = 1'b0;
                    clAck_d[rr_q] = 1'b1;
                    state_d      = ARB_XFER;
                end else if (timer_q == TW'(TIMEOUT - 1)) begin
                    sdRd_d       = 1'b0;
                    sdWr_d       = 1'b0;
                    clErr_d[rr_q] = 1'b1;
                    state_d      = ARB_IDLE;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            ARB_XFER: begin
                if (ackFall) begin
                    state_d = ARB_GAP;
                end else begin
                    clAck_d[rr_q] = sd_ack_i;
                end
            end
            ARB_GAP: begin
                state_d = ARB_IDLE;
            end
            default: begin
                state_d = ARB_IDLE;
            end
        endcase
    end

    // State and output registers. Reset starts the pointer at the last client
    // so that client 0 wins the first scan.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state_q   <= ARB_IDLE;
            rr_q      <= IW'(NCLI - 1);
            lba_q     <= '0;
            blkCnt_q  <= '0;
            timer_q   <= '0;
            sdRd_q    <= 1'b0;
            sdWr_q    <= 1'b0;
            clAck_q   <= '0;
            clErr_q   <= '0;
            ackPrev_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            rr_q      <= rr_d;
            lba_q     <= lba_d;
            blkCnt_q  <= blkCnt_d;
            timer_q   <= timer_d;
            sdRd_q    <= sdRd_d;
            sdWr_q    <= sdWr_d;
            clAck_q   <= clAck_d;
            clErr_q   <= clErr_d;
            ackPrev_q <= sd_ack_i;
        end
    end

    assign sd_lba_o      = lba_q;
    assign sd_blk_cnt_o  = blkCnt_q;
    assign sd_rd_o       = sdRd_q;
    assign sd_wr_o       = sdWr_q;
    assign cl_ack_o      = clAck_q;
    assign cl_err_o      = clErr_q;
    assign busy_o        = (state_q != ARB_IDLE);
    // Write data follows the granted client with no register stage.
    assign sd_buff_din_o = (state_q == ARB_REQ || state_q == ARB_XFER) ? buffArr[rr_q] : '0;

endmodule

// File: tb/tb_ieeedrv_sd_arb.sv
// tb_ieeedrv_sd_arb
// Self-checking bench for ieeedrv_sd_arb with two clients and a short timeout:
// a fixed cycle table, hand-written corner sequences (timeout, reset during a
// transfer, alternating grants) and randomized transactions predicted by a
// transaction-level round-robin model.
`timescale 1ns/1ps

module tb_ieeedrv_sd_arb;
    import ieeedrv_pkg::*;

    localparam int NCLI    = 2;
    localparam int TIMEOUT = 16;

    logic                     clk_sys = 1'b0;
    logic                     reset;
    logic [NCLI*SD_LBA_W-1:0] clLba;
    logic [NCLI*SD_CNT_W-1:0] clBlkCnt;
    logic [NCLI-1:0]          clRd;
    logic [NCLI-1:0]          clWr;
    logic [NCLI-1:0]          clAck;
    logic [NCLI*SD_DAT_W-1:0] clBuff;
    logic [NCLI-1:0]          clErr;
    logic [SD_LBA_W-1:0]      sdLba;
    logic [SD_CNT_W-1:0]      sdBlkCnt;
    logic                     sdRd;
    logic                     sdWr;
    logic                     sdAck;
    logic [SD_DAT_W-1:0]      sdBuff;
    logic                     busy;

    int testCount = 0;
    int failCount = 0;
    bit monitorOn = 1'b0;

    // Client-side model state: what each client currently asks for.
    logic                pRd   [NCLI];
    logic                pWr   [NCLI];
    logic [SD_LBA_W-1:0] lbaM  [NCLI];
    logic [SD_CNT_W-1:0] cntM  [NCLI];
    logic [SD_DAT_W-1:0] bufM  [NCLI];
    int                  lastServed;

    typedef struct {
        logic [1:0]  rd;
        logic [1:0]  wr;
        logic        ack;
        logic        expRd;
        logic        expWr;
        logic [1:0]  expAck;
        logic        expBusy;
        logic [31:0] expLba;
        logic        chkBuf;
        logic [7:0]  expBuf;
    } vec_t;

    vec_t vecs[$];

    ieeedrv_sd_arb #(.NCLI(NCLI), .TIMEOUT(TIMEOUT)) dut (
        .clk_sys      (clk_sys),
        .reset        (reset),
        .cl_lba_i     (clLba),
        .cl_blk_cnt_i (clBlkCnt),
        .cl_rd_i      (clRd),
        .cl_wr_i      (clWr),
        .cl_ack_o     (clAck),
        .cl_buff_din_i(clBuff),
        .cl_err_o     (clErr),
        .sd_lba_o     (sdLba),
        .sd_blk_cnt_o (sdBlkCnt),
        .sd_rd_o      (sdRd),
        .sd_wr_o      (sdWr),
        .sd_ack_i     (sdAck),
        .sd_buff_din_o(sdBuff),
        .busy_o       (busy)
    );

    always #5 clk_sys = ~clk_sys;

    // Two acks at once would mean two clients think they own the channel.
    always @(negedge clk_sys) begin
        if (monitorOn) begin
            testCount++;
            if ($countones(clAck) > 1) begin
                failCount++;
                $display("[TB] FAIL ack_onehot: cl_ack=%b, required at most one bit set", clAck);
            end
        end
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic applyStimulus();
        for (int i = 0; i < NCLI; i++) begin
            clRd[i] = pRd[i];
            clWr[i] = pWr[i];
            clLba[i*SD_LBA_W +: SD_LBA_W]    = lbaM[i];
            clBlkCnt[i*SD_CNT_W +: SD_CNT_W] = cntM[i];
            clBuff[i*SD_DAT_W +: SD_DAT_W]   = bufM[i];
        end
    endtask

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        testCount++;
        if (act !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [NCLI-1:0] oneHot(input int idx);
        return NCLI'(1) << idx;
    endfunction

    // Reference arbitration: line the clients up starting just after the one
    // served last, and the first one with a pending request wins.
    function automatic int modelWinner();
        int order[$];
        for (int k = 1; k <= NCLI; k++) begin
            order.push_back((lastServed + k) % NCLI);
        end
        foreach (order[j]) begin
            if (pRd[order[j]] || pWr[order[j]]) return order[j];
        end
        return -1;
    endfunction

    task automatic resetDut();
        reset = 1'b1;
        sdAck = 1'b0;
        for (int i = 0; i < NCLI; i++) begin
            pRd[i] = 1'b0;
            pWr[i] = 1'b0;
        end
        applyStimulus();
        tick();
        tick();
        reset = 1'b0;
        lastServed = NCLI - 1;
    endtask

    // One full transaction starting from an idle sample with requests driven.
    // dutServed reports which client the DUT actually granted (by address).
    task automatic doTransaction(input int ackDelay, input int hold, input bit noAck,
                                 input bit dropEarly, output int dutServed);
        int   w;
        int   hi;
        logic expRd;
        w = modelWinner();
        dutServed = -1;
        if (w < 0) begin
            checkOutput("model_has_request", 64'd0, 64'd1);
            return;
        end
        expRd = pRd[w];
        tick();
        for (int i = 0; i < NCLI; i++) begin
            if (sdLba == lbaM[i] && (sdRd || sdWr)) dutServed = i;
        end
        checkOutput("grant_strobe", {sdRd, sdWr}, {expRd, ~expRd});
        checkOutput("grant_lba", sdLba, lbaM[w]);
        checkOutput("grant_cnt", sdBlkCnt, cntM[w]);
        checkOutput("grant_flags", {clAck, clErr, busy}, {NCLI'(0), NCLI'(0), 1'b1});
        lastServed = w;
        if (dropEarly) begin
            pRd[w] = 1'b0;
            pWr[w] = 1'b0;
            applyStimulus();
        end
        if (noAck) begin
            hi = 1;
            for (int c = 0; c < 4*TIMEOUT; c++) begin
                tick();
                if (sdRd || sdWr) hi++;
                else break;
            end
            checkOutput("timeout_len", hi, TIMEOUT);
            checkOutput("timeout_err", {clErr, clAck, busy}, {oneHot(w), NCLI'(0), 1'b0});
            pRd[w] = 1'b0;
            pWr[w] = 1'b0;
            applyStimulus();
        end else begin
            repeat (ackDelay) begin
                tick();
                checkOutput("req_held", {sdRd, sdWr}, {expRd, ~expRd});
            end
            sdAck = 1'b1;
            tick();
            checkOutput("ack_route", {sdRd, sdWr, clAck}, {2'b00, oneHot(w)});
            repeat (hold) begin
                bufM[w] = 8'($urandom);
                applyStimulus();
                #1;
                checkOutput("xfer_buf", sdBuff, bufM[w]);
                tick();
                checkOutput("xfer_ack", clAck, oneHot(w));
            end
            sdAck = 1'b0;
            tick();
            checkOutput("gap", {clAck, busy}, {NCLI'(0), 1'b1});
            pRd[w] = 1'b0;
            pWr[w] = 1'b0;
            applyStimulus();
            tick();
            checkOutput("back_idle", {clAck, busy, sdBuff}, 64'd0);
        end
    endtask

    initial begin
        int s;
        vec_t v;

        // rd, wr, ack | sd_rd, sd_wr, cl_ack, busy, sd_lba, check buf?, buf
        vecs.push_back('{2'b01, 2'b00, 1'b0, 1'b1, 1'b0, 2'b00, 1'b1, 32'd357,  1'b0, 8'h00});
        vecs.push_back('{2'b01, 2'b00, 1'b0, 1'b1, 1'b0, 2'b00, 1'b1, 32'd357,  1'b0, 8'h00});
        vecs.push_back('{2'b01, 2'b00, 1'b1, 1'b0, 1'b0, 2'b01, 1'b1, 32'd357,  1'b1, 8'h3C});
        vecs.push_back('{2'b01, 2'b00, 1'b1, 1'b0, 1'b0, 2'b01, 1'b1, 32'd357,  1'b1, 8'h3C});
        vecs.push_back('{2'b01, 2'b00, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 32'd357,  1'b1, 8'h00});
        vecs.push_back('{2'b00, 2'b10, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 32'd357,  1'b1, 8'h00});
        vecs.push_back('{2'b00, 2'b10, 1'b0, 1'b0, 1'b1, 2'b00, 1'b1, 32'd1000, 1'b0, 8'h00});
        vecs.push_back('{2'b00, 2'b10, 1'b1, 1'b0, 1'b0, 2'b10, 1'b1, 32'd1000, 1'b1, 8'hA5});
        vecs.push_back('{2'b00, 2'b10, 1'b1, 1'b0, 1'b0, 2'b10, 1'b1, 32'd1000, 1'b1, 8'hA5});
        vecs.push_back('{2'b00, 2'b10, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 32'd1000, 1'b1, 8'h00});
        vecs.push_back('{2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 32'd1000, 1'b1, 8'h00});
        vecs.push_back('{2'b01, 2'b10, 1'b0, 1'b1, 1'b0, 2'b00, 1'b1, 32'd357,  1'b0, 8'h00});
        vecs.push_back('{2'b01, 2'b10, 1'b1, 1'b0, 1'b0, 2'b01, 1'b1, 32'd357,  1'b1, 8'h3C});
        vecs.push_back('{2'b01, 2'b10, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 32'd357,  1'b1, 8'h00});
        vecs.push_back('{2'b00, 2'b10, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 32'd357,  1'b1, 8'h00});
        vecs.push_back('{2'b00, 2'b10, 1'b0, 1'b0, 1'b1, 2'b00, 1'b1, 32'd1000, 1'b0, 8'h00});
        vecs.push_back('{2'b00, 2'b10, 1'b1, 1'b0, 1'b0, 2'b10, 1'b1, 32'd1000, 1'b1, 8'hA5});
        vecs.push_back('{2'b00, 2'b10, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 32'd1000, 1'b1, 8'h00});
        vecs.push_back('{2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 32'd1000, 1'b1, 8'h00});
        vecs.push_back('{2'b01, 2'b01, 1'b0, 1'b1, 1'b0, 2'b00, 1'b1, 32'd357,  1'b0, 8'h00});
        vecs.push_back('{2'b01, 2'b01, 1'b1, 1'b0, 1'b0, 2'b01, 1'b1, 32'd357,  1'b1, 8'h3C});
        vecs.push_back('{2'b01, 2'b01, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 32'd357,  1'b1, 8'h00});
        vecs.push_back('{2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 32'd357,  1'b1, 8'h00});

        lbaM[0] = 32'd357;  cntM[0] = 6'd3; bufM[0] = 8'h3C;
        lbaM[1] = 32'd1000; cntM[1] = 6'd7; bufM[1] = 8'hA5;

        // Reset state.
        resetDut();
        monitorOn = 1'b1;
        checkOutput("reset_state", {sdRd, sdWr, clAck, clErr, busy, sdLba, sdBlkCnt, sdBuff}, 64'd0);

        // Cycle table: single read, write with data, simultaneous requests, rd+wr.
        for (int r = 0; r < vecs.size(); r++) begin
            v = vecs[r];
            for (int i = 0; i < NCLI; i++) begin
                pRd[i] = v.rd[i];
                pWr[i] = v.wr[i];
            end
            sdAck = v.ack;
            applyStimulus();
            tick();
            checkOutput($sformatf("vec%0d", r), {sdRd, sdWr, clAck, clErr, busy, sdLba},
                        {v.expRd, v.expWr, v.expAck, 2'b00, v.expBusy, v.expLba});
            if (v.chkBuf) begin
                checkOutput($sformatf("vec%0d_buf", r), sdBuff, v.expBuf);
            end
        end

        // Timeout with no host ack, then the error pulse must be gone.
        resetDut();
        pRd[0] = 1'b1;
        applyStimulus();
        doTransaction(0, 0, 1'b1, 1'b0, s);
        tick();
        checkOutput("err_one_pulse", {clErr, busy, sdRd}, 64'd0);

        // Reset during a transfer while the host still holds ack.
        resetDut();
        pRd[1] = 1'b1;
        lbaM[1] = 32'h0BAD_F00D;
        applyStimulus();
        tick();
        checkOutput("midop_grant", {sdRd, sdLba}, {1'b1, 32'h0BAD_F00D});
        sdAck = 1'b1;
        tick();
        checkOutput("midop_xfer", clAck, 2'b10);
        reset = 1'b1;
        tick();
        checkOutput("midop_reset", {sdRd, sdWr, clAck, clErr, busy, sdLba, sdBlkCnt, sdBuff}, 64'd0);
        reset = 1'b0;
        repeat (3) begin
            tick();
            checkOutput("stale_ack_wait", {sdRd, sdWr, busy}, 3'b000);
        end
        sdAck = 1'b0;
        tick();
        checkOutput("regrant", {sdRd, sdLba}, {1'b1, 32'h0BAD_F00D});
        sdAck = 1'b1;
        tick();
        sdAck = 1'b0;
        tick();
        pRd[1] = 1'b0;
        applyStimulus();
        tick();

        // Both clients keep re-requesting: grants must alternate 0,1,0,1.
        resetDut();
        lbaM[0] = 32'h0000_1111;
        lbaM[1] = 32'h0000_2222;
        pRd[0] = 1'b1;
        pWr[1] = 1'b1;
        applyStimulus();
        for (int t = 0; t < 4; t++) begin
            doTransaction(1, 1, 1'b0, 1'b0, s);
            checkOutput($sformatf("alternate%0d", t), s, t % 2);
            if (t % 2 == 0) pRd[0] = 1'b1;
            else            pWr[1] = 1'b1;
            applyStimulus();
        end

        // Randomized transactions against the round-robin model.
        resetDut();
        for (int n = 0; n < 50; n++) begin
            int anyPending;
            anyPending = 0;
            for (int i = 0; i < NCLI; i++) begin
                if (!(pRd[i] || pWr[i]) && ($urandom % 2 == 0)) begin
                    case ($urandom % 3)
                        0:       begin pRd[i] = 1'b1; pWr[i] = 1'b0; end
                        1:       begin pRd[i] = 1'b0; pWr[i] = 1'b1; end
                        default: begin pRd[i] = 1'b1; pWr[i] = 1'b1; end
                    endcase
                    lbaM[i] = $urandom;
                    cntM[i] = 6'($urandom);
                    bufM[i] = 8'($urandom);
                end
                if (pRd[i] || pWr[i]) anyPending = 1;
            end
            if (anyPending == 0) begin
                s = int'($urandom % NCLI);
                pRd[s] = 1'b1;
                lbaM[s] = $urandom;
                cntM[s] = 6'($urandom);
            end
            applyStimulus();
            doTransaction(int'($urandom % 6), 1 + int'($urandom % 4),
                          ($urandom % 6) == 0, ($urandom % 4) == 0, s);
        end

        monitorOn = 1'b0;
        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
